// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one unified memory.
// Optional MEM_ARB_RR_EN: round-robin on contention, else data first.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [9:0]  i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [1:0]  d_op,
  input  logic [9:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [1:0]  mem_op,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [1:0]  op_d;
  logic [9:0]  addr_d;
  logic [31:0] wdata_d;
  logic        i_ack_d, d_ack_d;
  logic [31:0] i_rdata_d, d_rdata_d;
  logic        d_elig, i_elig;
  logic        grant_d, grant_i;

`ifdef MEM_ARB_RR_EN
  logic last_d, last_d_d;
`endif

  assign busy = (state != IDLE);

  // A port is eligible unless in service or acked this cycle
  always_comb begin
    d_elig = d_req & (state != DATA) & ~d_ack;
    i_elig = i_req & (state != FETCH) & ~i_ack;
`ifdef MEM_ARB_RR_EN
    grant_d = d_elig & (~i_elig | ~last_d);
`else
    grant_d = d_elig;
`endif
    grant_i = i_elig & ~grant_d;
  end

  // Next state, next memory command, completion capture
  always_comb begin
    state_d   = IDLE;
    op_d      = 2'b00;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    i_ack_d   = (state == FETCH);
    d_ack_d   = (state == DATA);
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
`ifdef MEM_ARB_RR_EN
    last_d_d  = last_d;
`endif
    if (state == FETCH) i_rdata_d = mem_rdata;
    if (state == DATA && mem_op == 2'b00) d_rdata_d = mem_rdata;
    unique case (1'b1)
      grant_d: begin
        state_d = DATA;
        op_d    = d_op;
        addr_d  = d_addr;
        wdata_d = d_wdata;
`ifdef MEM_ARB_RR_EN
        last_d_d = 1'b1;
`endif
      end
      grant_i: begin
        state_d = FETCH;
        addr_d  = i_addr;
        wdata_d = 32'd0;
`ifdef MEM_ARB_RR_EN
        last_d_d = 1'b0;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register state, memory command, acks and read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_op    <= 2'b00;
      mem_addr  <= 10'd0;
      mem_wdata <= 32'd0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      state     <= state_d;
      mem_op    <= op_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      i_ack     <= i_ack_d;
      d_ack     <= d_ack_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last-served flag; starts as fetch so data wins first contention
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_d <= 1'b0;
    else      last_d <= last_d_d;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed memory model.
// Works with or without MEM_ARB_RR_EN defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [9:0]  i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [1:0]  d_op;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [1:0]  mem_op;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int passed = 0;
  int total  = 0;
  int n_dack, n_iack;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic [7:0] mem [0:1023];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_op(d_op),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = {mem[mem_addr + 10'd3], mem[mem_addr + 10'd2],
                      mem[mem_addr + 10'd1], mem[mem_addr]};

  always @(posedge clk) begin
    if (rst) begin
      case (mem_op)
        2'b01: mem[mem_addr] <= mem_wdata[7:0];
        2'b10: begin
          mem[mem_addr]         <= mem_wdata[7:0];
          mem[mem_addr + 10'd1] <= mem_wdata[15:8];
        end
        2'b11: begin
          mem[mem_addr]         <= mem_wdata[7:0];
          mem[mem_addr + 10'd1] <= mem_wdata[15:8];
          mem[mem_addr + 10'd2] <= mem_wdata[23:16];
          mem[mem_addr + 10'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
    mem[10'h010] = 8'h13;
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_op = '0; d_addr = '0; d_wdata = '0;
    nedge(); nedge();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_memop", {30'd0, mem_op}, 32'd0);
    chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_irdata", i_rdata, 32'd0);
    chk("rst_drdata", d_rdata, 32'd0);
    rst = 1'b1;

    // fetch 0x010
    i_req = 1'b1; i_addr = 10'h010;
    nedge();
    chk("f_busy", {31'd0, busy}, 32'd1);
    chk("f_memop", {30'd0, mem_op}, 32'd0);
    chk("f_addr", {22'd0, mem_addr}, 32'h010);
    chk("f_ack_early", {31'd0, i_ack}, 32'd0);
    nedge();
    chk("f_ack", {31'd0, i_ack}, 32'd1);
    chk("f_rdata", i_rdata, 32'h00000013);
    chk("f_idle", {31'd0, busy}, 32'd0);
    i_req = 1'b0;
    nedge();
    chk("f_ack_pulse", {31'd0, i_ack}, 32'd0);
    chk("f_rdata_hold", i_rdata, 32'h00000013);

    // store word
    d_req = 1'b1; d_op = 2'b11; d_addr = 10'h020;
    d_wdata = 32'hDEADBEEF;
    nedge();
    chk("sw_op", {30'd0, mem_op}, 32'd3);
    chk("sw_addr", {22'd0, mem_addr}, 32'h020);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    nedge();
    chk("sw_ack", {31'd0, d_ack}, 32'd1);
    chk("sw_drdata", d_rdata, 32'd0);
    // load issued during ack cycle: must wait one more edge
    d_op = 2'b00; d_wdata = 32'h0;
    nedge();
    chk("ld_wait", {31'd0, busy}, 32'd0);
    chk("ld_ack_low", {31'd0, d_ack}, 32'd0);
    nedge();
    chk("ld_busy", {31'd0, busy}, 32'd1);
    chk("ld_op", {30'd0, mem_op}, 32'd0);
    d_addr = 10'h3FF;
    chk("ld_addr", {22'd0, mem_addr}, 32'h020);
    nedge();
    chk("ld_ack", {31'd0, d_ack}, 32'd1);
    chk("ld_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0; d_addr = 10'h020;
    nedge();

    // simultaneous requests from idle
    d_req = 1'b1; i_req = 1'b1;
    nedge();
    chk("both_first", {22'd0, mem_addr}, RR ? 32'h010 : 32'h020);
    nedge();
    chk("both_second", {22'd0, mem_addr}, RR ? 32'h020 : 32'h010);
    chk("both_acks1", {30'd0, i_ack, d_ack}, RR ? 32'd2 : 32'd1);
    if (d_ack) d_req = 1'b0;
    if (i_ack) i_req = 1'b0;
    nedge();
    chk("both_acks2", {30'd0, i_ack, d_ack}, RR ? 32'd1 : 32'd2);
    chk("both_irdata", i_rdata, 32'h00000013);
    chk("both_drdata", d_rdata, 32'hDEADBEEF);
    chk("both_idle", {31'd0, busy}, 32'd0);
    d_req = 1'b0; i_req = 1'b0;
    nedge();

    // both held continuously for six edges
    n_dack = 0; n_iack = 0;
    d_req = 1'b1; i_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      nedge();
      n_dack += int'(d_ack);
      n_iack += int'(i_ack);
    end
    chk("hold_dacks", n_dack, 32'd2);
    chk("hold_iacks", n_iack, 32'd2);
    d_req = 1'b0; i_req = 1'b0;
    nedge(); nedge();
    chk("hold_idle", {31'd0, busy}, 32'd0);

    // reset during a store byte
    d_req = 1'b1; d_op = 2'b01; d_addr = 10'h030;
    d_wdata = 32'h000000A5;
    nedge();
    chk("rs_op", {30'd0, mem_op}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rs_op0", {30'd0, mem_op}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_addr", {22'd0, mem_addr}, 32'd0);
    nedge();
    chk("rs_noack", {31'd0, d_ack}, 32'd0);
    chk("rs_nowrite", {24'd0, mem[10'h030]}, 32'd0);
    rst = 1'b1;
    nedge();
    chk("rs_reop", {30'd0, mem_op}, 32'd1);
    chk("rs_readdr", {22'd0, mem_addr}, 32'h030);
    nedge();
    chk("rs_ack", {31'd0, d_ack}, 32'd1);
    chk("rs_write", {24'd0, mem[10'h030]}, 32'hA5);
    chk("rs_drdata", d_rdata, 32'd0);
    d_req = 1'b0;
    nedge();
    chk("rs_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
